// File: rtl/pcs_tx_ctrl_if.sv
// MAC transmit port of the 1000BASE-T PCS transmit sequencer.
// Handshake: a frame start transfers on a clock where mac_tx_en and mac_tx_ready
// are both high. The MAC holds mac_tx_en and the first octet until then, and
// afterwards streams one octet per clock with no backpressure until mac_tx_en falls.
interface pcs_tx_ctrl_if;
  logic       mac_tx_en;
  logic       mac_tx_er;
  logic [7:0] mac_txd;
  logic       mac_tx_ready;

  modport master (output mac_tx_en, output mac_tx_er, output mac_txd, input mac_tx_ready);
  modport slave  (input mac_tx_en, input mac_tx_er, input mac_txd, output mac_tx_ready);
endinterface

// File: rtl/pcs_tx_ctrl.sv
// Transmit sequencer feeding the 1000BASE-T PCS symbol encoder (ZERO/IDLE/XMIT/ESD/IPG).
// Define PCS_TX_STATS_EN to build the saturating frame/abort statistics counters.
module pcs_tx_ctrl #(
  parameter int MIN_IPG = 12,
  parameter int N_W     = 32,
  parameter int STAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  pcs_tx_ctrl_if.slave      mac,
  input  logic [1:0]        tx_mode_req,
  input  logic              loc_rcvr_status,
  output logic              enc_tx_enable,
  output logic              enc_tx_error,
  output logic [7:0]        enc_tx_data,
  output logic              enc_tx_mode,
  output logic              enc_send_z,
  output logic [N_W-1:0]    enc_n,
  output logic [N_W-1:0]    enc_n0,
  output logic              enc_loc_rcvr_status,
  output logic [2:0]        state_o,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] abort_cnt
);

  typedef enum logic [2:0] {
    ST_ZERO = 3'd0,
    ST_IDLE = 3'd1,
    ST_XMIT = 3'd2,
    ST_ESD  = 3'd3,
    ST_IPG  = 3'd4
  } state_t;

  // One counter serves both the 2-cycle ESD and the MIN_IPG gap.
  localparam int CNT_W = (MIN_IPG > 2) ? $clog2(MIN_IPG) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             aborted, aborted_nx;
  logic             en_nx, err_nx, mode_nx, ready_nx;
  logic [7:0]       data_nx;
  logic [N_W-1:0]   n_nx, n0_nx;
  logic             mode_z, mode_n;

  assign mode_z  = (tx_mode_req == 2'd0) || (tx_mode_req == 2'd3);
  assign mode_n  = (tx_mode_req == 2'd2);
  assign state_o = state;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    aborted_nx = aborted;
    en_nx      = 1'b0;
    err_nx     = 1'b0;
    data_nx    = 8'h00;
    n0_nx      = enc_n0;
    case (state)
      ST_ZERO: begin
        if (!mode_z) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (mac.mac_tx_en && mac.mac_tx_ready) begin
          state_nx   = ST_XMIT;
          n0_nx      = enc_n;
          en_nx      = 1'b1;
          data_nx    = mac.mac_txd;
          err_nx     = mac.mac_tx_er;
          aborted_nx = 1'b0;
        end
      end
      ST_XMIT: begin
        // Receiver loss poisons every octet after the one it was seen on.
        if (!loc_rcvr_status) aborted_nx = 1'b1;
        if (mac.mac_tx_en) begin
          en_nx   = 1'b1;
          data_nx = mac.mac_txd;
          err_nx  = mac.mac_tx_er | aborted;
        end else if (mac.mac_tx_er && (mac.mac_txd == 8'h0F)) begin
          data_nx = mac.mac_txd;
          err_nx  = 1'b1;
        end else begin
          state_nx = ST_ESD;
          cnt_nx   = '0;
        end
      end
      ST_ESD: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_IPG;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_IPG: begin
        if (cnt == CNT_W'(MIN_IPG - 1)) state_nx = ST_IDLE;
        else                            cnt_nx   = cnt + CNT_W'(1);
      end
      default: state_nx = ST_ZERO;
    endcase

    if (mode_z) begin
      state_nx   = ST_ZERO;
      en_nx      = 1'b0;
      err_nx     = 1'b0;
      data_nx    = 8'h00;
      n0_nx      = enc_n0;
      aborted_nx = 1'b0;
    end

    ready_nx = (state_nx == ST_IDLE) && mode_n && loc_rcvr_status;
    n_nx     = (state_nx != ST_ZERO) ? enc_n + N_W'(1) : enc_n;
    if (state_nx == ST_ZERO)      mode_nx = 1'b0;
    else if (state_nx == ST_IDLE) mode_nx = mode_n;
    else                          mode_nx = enc_tx_mode;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= ST_ZERO;
      cnt                 <= '0;
      aborted             <= 1'b0;
      enc_tx_enable       <= 1'b0;
      enc_tx_error        <= 1'b0;
      enc_tx_data         <= 8'h00;
      enc_tx_mode         <= 1'b0;
      enc_send_z          <= 1'b1;
      enc_n               <= '0;
      enc_n0              <= '0;
      enc_loc_rcvr_status <= 1'b0;
      mac.mac_tx_ready    <= 1'b0;
    end else begin
      state               <= state_nx;
      cnt                 <= cnt_nx;
      aborted             <= aborted_nx;
      enc_tx_enable       <= en_nx;
      enc_tx_error        <= err_nx;
      enc_tx_data         <= data_nx;
      enc_tx_mode         <= mode_nx;
      enc_send_z          <= (state_nx == ST_ZERO);
      enc_n               <= n_nx;
      enc_n0              <= n0_nx;
      enc_loc_rcvr_status <= loc_rcvr_status;
      mac.mac_tx_ready    <= ready_nx;
    end
  end

`ifdef PCS_TX_STATS_EN
  logic start_evt, abort_evt;

  assign start_evt = (state == ST_IDLE) && mac.mac_tx_en && mac.mac_tx_ready && !mode_z;
  // At most one abort per frame: the sticky flag blocks a second count.
  assign abort_evt = (state == ST_XMIT) && !aborted && (!loc_rcvr_status || mode_z);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (start_evt && !(&frame_cnt)) frame_cnt <= frame_cnt + STAT_W'(1);
      if (abort_evt && !(&abort_cnt)) abort_cnt <= abort_cnt + STAT_W'(1);
    end
  end
`else
  assign frame_cnt = '0;
  assign abort_cnt = '0;
`endif

endmodule

// File: doc/pcs_tx_ctrl.md
Name: pcs_tx_ctrl

Overview:
- Transmit-side sequencer for the 1000BASE-T PCS symbol encoder.
- Accepts GMII-style frames from the MAC and drives the encoder's enable, error, data, mode and symbol-index inputs (n, n0).
- Enforces the PMA transmit mode (SEND_Z / SEND_I / SEND_N), the minimum inter-packet gap and frame abort on receiver-status loss.
- Sits between the MAC TX interface and the Encoder instance.

Parameters:
MIN_IPG, 12, idle symbol periods forced after ESD before a new frame may start (>=1)
N_W, 32, width of the symbol counters n and n0
STAT_W, 16, width of the statistics counters

Ports:
clock  in  1  PCS symbol clock (125 MHz)
reset  in  1  asynchronous, active-high reset
mac_tx_en  in  1  MAC frame-valid
mac_tx_er  in  1  MAC error / carrier-extend flag
mac_txd  in  8  MAC data octet
mac_tx_ready  out  1  high when a frame start will be accepted this cycle
tx_mode_req  in  2  0=SEND_Z, 1=SEND_I, 2=SEND_N, 3=reserved (treated as SEND_Z)
loc_rcvr_status  in  1  local receiver OK
enc_tx_enable  out  1  to Encoder io_tx_enable
enc_tx_error  out  1  to Encoder io_tx_error
enc_tx_data  out  8  to Encoder io_tx_data
enc_tx_mode  out  1  to Encoder io_tx_mode (1 = SEND_N, 0 = SEND_I)
enc_send_z  out  1  high in SEND_Z; downstream forces zero symbols
enc_n  out  N_W  symbol index to Encoder io_n
enc_n0  out  N_W  n captured at frame start, to Encoder io_n0
enc_loc_rcvr_status  out  1  registered copy of loc_rcvr_status
state_o  out  3  current FSM state, for debug
frame_cnt  out  STAT_W  frames started (see Optional Feature)
abort_cnt  out  STAT_W  frames aborted (see Optional Feature)

Behaviour:
- All enc_* outputs, mac_tx_ready, state_o and counters are registered; one-cycle latency from inputs.
- Reset values: state ZERO, enc_send_z=1, mac_tx_ready=0, every other output 0.
- States: ZERO(0), IDLE(1), XMIT(2), ESD(3), IPG(4).
- ZERO:
  - enc_tx_enable=0, n held.
  - Leave to IDLE when tx_mode_req is 1 or 2.
- Counter n:
  - enc_n increments by 1 every cycle outside ZERO.
  - Wraps from 2^N_W-1 to 0 with no other effect.
- IDLE:
  - enc_tx_mode=(tx_mode_req==2).
  - mac_tx_ready=1 only when tx_mode_req==2 and loc_rcvr_status==1.
  - mac_tx_en & mac_tx_ready -> XMIT: enc_n0 <= enc_n current value, enc_tx_enable=1, frame_cnt++.
- XMIT:
  - enc_tx_data=mac_txd and enc_tx_error=mac_tx_er, passed through registered.
  - The Encoder emits SSD1/SSD2 itself on its first two enabled cycles; the controller adds no extra delay.
- Frame end: mac_tx_en falling in XMIT -> enc_tx_enable=0.
  - If mac_tx_er=1 and mac_txd=0x0F, remain in XMIT with enc_tx_error=1 (carrier extension) until mac_tx_er drops.
  - Otherwise go to ESD.
- ESD: fixed 2 cycles, covering ESD1 and ESD2, then IPG.
- IPG:
  - Counts MIN_IPG cycles with mac_tx_ready=0, then IDLE.
  - mac_tx_en during IPG is ignored; the MAC must hold it until ready.
- Abort: loc_rcvr_status=0 during XMIT -> enc_tx_error=1 from the next cycle to frame end; abort_cnt++ once per frame.
- tx_mode_req change to SEND_I during XMIT:
  - The frame completes normally.
  - No new frame starts until the mode returns to SEND_N.
- tx_mode_req change to SEND_Z in any state:
  - Next cycle: state ZERO, enc_tx_enable=0, enc_send_z=1.
  - If a frame was in flight, abort_cnt++.
- Asynchronous reset mid-frame returns to reset values immediately; no ESD is generated.
- Statistics counters saturate at all-ones.

Optional Feature:
- Macro PCS_TX_STATS_EN.
- Defined: frame_cnt and abort_cnt are implemented as specified.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized; FSM behaviour is identical.

Test Plan:
- Reset held 4 cycles, tx_mode_req=2, then 8-octet frame 0x00..0x07 -> enc_tx_enable high exactly 8 cycles; enc_n0 equals enc_n at the start cycle; enc_tx_data matches 1 cycle late; ESD 2 cycles; mac_tx_ready low for 12 cycles, then high.
- Back-to-back frames with mac_tx_en re-asserted 1 cycle after frame end -> second frame start delayed until IPG done; frame_cnt=2.
- loc_rcvr_status dropped at octet 3 of a 10-octet frame -> enc_tx_error=1 from octet 4 to end; abort_cnt=1.
- tx_mode_req=0 mid-frame -> next cycle enc_send_z=1, enc_tx_enable=0, enc_n frozen; return to 2 -> n resumes from the frozen value.
- Carrier extension: mac_tx_en falls with mac_tx_er=1, mac_txd=0x0F for 5 cycles -> enc_tx_error=1 for 5 cycles, then ESD.
- Force enc_n to 0xFFFFFFFE via 2 increments -> wraps to 0; frame started on the wrap cycle -> enc_n0=0.
